eprobe_pixel_receiver: RTL and testbench

- Probe-side receiver for the uLED pixel-update bus driven by the EProbe controller.
- Captures each load strobe and stores {en_led, vled} per LED in a 1024-entry shadow register bank addressed by {probe, addr, pix}.
- Tracks enabled-LED count and bulk (all-pixel) sweep completion, and provides host readback.
- Used as the on-FPGA probe model for loopback and as the verification scoreboard target.

---
 rtl/eprobe_pixel_receiver.sv | 197 +++++++++++++++++++
 tb/tb_eprobe_pixel_receiver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eprobe_pixel_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : eprobe_pixel_receiver                                         |
// | Purpose  : Probe-side uLED pixel-bus receiver with a shadow register     |
// |            bank, enabled-LED count, bulk-sweep tracking and readback.    |
// |            Optional load-hold bus check enabled by the macro             |
// |            EPROBE_RX_HOLD_CHECK_EN.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module eprobe_pixel_receiver #(
  parameter int NUM_LED = 1024,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        probe,
  input  logic [5:0]        addr,
  input  logic [1:0]        pix,
  input  logic [2:0]        vled,
  input  logic              en_led,
  input  logic              load,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [3:0]        rd_data,
  output logic [ADDR_W:0]   active_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              bulk_done,
  output logic              bulk_abort,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(NUM_LED - 1);
  localparam logic [ADDR_W:0]   c_act_one = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   c_act_max = (ADDR_W + 1)'(NUM_LED);
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);

  typedef enum logic [0:0] {
    B_IDLE = 1'b0,
    B_RUN  = 1'b1
  } bulk_state_t;

  logic              r_load_q;
  logic              r_armed;
  logic              w_wr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_old_en;
  logic [NUM_LED-1:0] r_en;
  logic [2:0]        r_vled [NUM_LED];

  bulk_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_expect, w_expect_nxt;
  logic              w_done_nxt, w_abort_nxt;

  assign w_wr_addr = {probe, addr, pix};
  assign w_old_en  = r_en[w_wr_addr];
  // A load already high as reset releases must first be seen low before it can commit.
  assign w_wr      = load & ~r_load_q & r_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_load_q <= load;
      r_armed  <= r_armed | ~load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        r_vled[i] <= '0;
      end
    end else if (w_wr) begin
      r_en[w_wr_addr]   <= en_led;
      r_vled[w_wr_addr] <= vled;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_cnt <= '0;
      wr_cnt     <= '0;
    end else if (w_wr) begin
      if (en_led && !w_old_en && active_cnt != c_act_max) begin
        active_cnt <= active_cnt + c_act_one;
      end else if (!en_led && w_old_en && active_cnt != '0) begin
        active_cnt <= active_cnt - c_act_one;
      end
      if (wr_cnt != '1) begin
        wr_cnt <= wr_cnt + c_cnt_one;
      end
    end
  end

  // Readback with write-first bypass so a same-cycle write is never missed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (w_wr && w_wr_addr == rd_addr) begin
          rd_data <= {en_led, vled};
        end else begin
          rd_data <= {r_en[rd_addr], r_vled[rd_addr]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= B_IDLE;
      r_expect   <= '0;
      bulk_done  <= 1'b0;
      bulk_abort <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_expect   <= w_expect_nxt;
      bulk_done  <= w_done_nxt;
      bulk_abort <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_expect_nxt = r_expect;
    w_done_nxt   = 1'b0;
    w_abort_nxt  = 1'b0;
    if (w_wr) begin
      case (r_state)
        B_IDLE: begin
          if (w_wr_addr == '0) begin
            w_state_nxt  = B_RUN;
            w_expect_nxt = c_addr_one;
          end
        end
        B_RUN: begin
          if (w_wr_addr == r_expect) begin
            if (w_wr_addr == c_addr_last) begin
              w_done_nxt   = 1'b1;
              w_state_nxt  = B_IDLE;
              w_expect_nxt = '0;
            end else begin
              w_expect_nxt = r_expect + c_addr_one;
            end
          end else begin
            // A broken sweep that lands on address 0 is treated as a fresh start.
            w_abort_nxt = 1'b1;
            if (w_wr_addr == '0) begin
              w_state_nxt  = B_RUN;
              w_expect_nxt = c_addr_one;
            end else begin
              w_state_nxt  = B_IDLE;
              w_expect_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt  = B_IDLE;
          w_expect_nxt = '0;
        end
      endcase
    end
  end

`ifdef EPROBE_RX_HOLD_CHECK_EN
  logic [13:0] r_cap;
  logic [13:0] w_bus;

  assign w_bus = {probe, addr, pix, vled, en_led};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap <= '0;
      err   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_cap <= w_bus;
      end
      if (load && r_load_q && w_bus != r_cap) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eprobe_pixel_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_eprobe_pixel_receiver                                      |
// | Purpose  : Randomized self-checking bench for eprobe_pixel_receiver      |
// |            against a behavioural shadow-bank model.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_eprobe_pixel_receiver;

  localparam int NUM_LED = 1024;
  localparam int CNT_W   = 11;
  localparam int WR_MAX  = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst;
  logic [1:0]  probe;
  logic [5:0]  addr;
  logic [1:0]  pix;
  logic [2:0]  vled;
  logic        en_led;
  logic        load;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic [10:0] active_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic        bulk_done;
  logic        bulk_abort;
  logic        err;

  eprobe_pixel_receiver #(
    .NUM_LED(NUM_LED),
    .ADDR_W (10),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe     (probe),
    .addr      (addr),
    .pix       (pix),
    .vled      (vled),
    .en_led    (en_led),
    .load      (load),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .active_cnt(active_cnt),
    .wr_cnt    (wr_cnt),
    .bulk_done (bulk_done),
    .bulk_abort(bulk_abort),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: shadow contents, write count, sweep progress, sticky error.
  bit [2:0]        m_vled [NUM_LED];
  bit [NUM_LED-1:0] m_en;
  int              m_wr;
  bit              m_run;
  int              m_next;
  bit              m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LED; i++) m_vled[i] = '0;
    m_en   = '0;
    m_wr   = 0;
    m_run  = 1'b0;
    m_next = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_write(input int a, input bit en, input bit [2:0] v,
                             output bit d, output bit ab);
    d  = 1'b0;
    ab = 1'b0;
    m_en[a]   = en;
    m_vled[a] = v;
    if (m_wr < WR_MAX) m_wr++;
    if (!m_run) begin
      if (a == 0) begin
        m_run  = 1'b1;
        m_next = 1;
      end
    end else if (a == m_next) begin
      if (a == NUM_LED - 1) begin
        d     = 1'b1;
        m_run = 1'b0;
      end else begin
        m_next++;
      end
    end else begin
      ab = 1'b1;
      if (a == 0) m_next = 1;
      else m_run = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_rd(input int a);
    return 32'({m_en[a], m_vled[a]});
  endfunction

  task automatic do_write(input int a, input bit en, input bit [2:0] v, input int hold);
    bit ed, ea;
    {probe, addr, pix} = 10'(a);
    en_led = en;
    vled   = v;
    load   = 1'b1;
    @(negedge clk);
    model_write(a, en, v, ed, ea);
    chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
    chk("active_cnt", 32'(active_cnt), 32'($countones(m_en)));
    chk("bulk_done", 32'(bulk_done), 32'(ed));
    chk("bulk_abort", 32'(bulk_abort), 32'(ea));
    chk("err", 32'(err), 32'(m_err));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("hold_wr_cnt", 32'(wr_cnt), 32'(m_wr));
      chk("hold_pulses", 32'({bulk_done, bulk_abort}), 32'(0));
    end
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_burst(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(NUM_LED - 1));
      rd_req  = 1'b1;
      rd_addr = 10'(a);
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'(1));
      chk("rd_data", 32'(rd_data), m_rd(a));
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_idle", 32'(rd_valid), 32'(0));
  endtask

  task automatic read_one(input int a);
    rd_req  = 1'b1;
    rd_addr = 10'(a);
    @(negedge clk);
    rd_req = 1'b0;
    chk("rd1_valid", 32'(rd_valid), 32'(1));
    chk("rd1_data", 32'(rd_data), m_rd(a));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    chk({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    chk({tag, "_active"}, 32'(active_cnt), 32'(0));
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(0));
    chk({tag, "_done"}, 32'(bulk_done), 32'(0));
    chk({tag, "_abort"}, 32'(bulk_abort), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, len, brk, n;
    int done_seen;
    bit ed, ea;
    bit [2:0] v;

    rst = 1'b0; load = 1'b1; rd_req = 1'b0; rd_addr = '0;
    {probe, addr, pix} = '0; vled = '0; en_led = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // load already high as reset releases must not commit
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("load_high_at_release", 32'(wr_cnt), 32'(0));
    load = 1'b0;
    @(negedge clk);

    // single write held 3 cycles
    do_write('h2A5, 1'b1, 3'd5, 3);
    read_one('h2A5);
    chk("tp_single_rd", 32'(rd_data), 32'('hD));
    chk("tp_single_active", 32'(active_cnt), 32'(1));
    chk("tp_single_wr", 32'(wr_cnt), 32'(1));

    // disable same LED
    do_write('h2A5, 1'b0, 3'd5, 1);
    read_one('h2A5);
    chk("tp_dis_rd", 32'(rd_data), 32'('h5));
    chk("tp_dis_active", 32'(active_cnt), 32'(0));
    chk("tp_dis_wr", 32'(wr_cnt), 32'(2));

    // full sweep
    for (int i = 0; i < NUM_LED; i++) do_write(i, 1'b1, 3'd3, 1);
    chk("tp_sweep_active", 32'(active_cnt), 32'(NUM_LED));
    read_burst(4);

    // broken sweep 0,1,2,5 then 6
    do_write(0, 1'b1, 3'd1, 1);
    do_write(1, 1'b1, 3'd1, 1);
    do_write(2, 1'b1, 3'd1, 1);
    do_write(5, 1'b1, 3'd1, 1);
    do_write(6, 1'b1, 3'd1, 1);

    // randomized traffic with partial and broken sweeps mixed in
    n = 0;
    done_seen = 0;
    while (n < 1200) begin
      if ($urandom_range(3) == 0) begin
        len = int'($urandom_range(40, 1));
        brk = int'($urandom_range(80, 0));
        for (int k = 0; k < len; k++) begin
          a = (k == brk) ? int'($urandom_range(NUM_LED - 1)) : k;
          do_write(a, 1'($urandom), 3'($urandom), int'($urandom_range(3, 1)));
          n++;
        end
      end else begin
        do_write(int'($urandom_range(NUM_LED - 1)), 1'($urandom), 3'($urandom),
                 int'($urandom_range(3, 1)));
        n++;
      end
      if ($urandom_range(7) == 0) read_burst(int'($urandom_range(6, 1)));
    end
    chk("wr_cnt_saturated", 32'(wr_cnt), 32'(WR_MAX));

    // write and read the same address in the same cycle
    v = 3'($urandom);
    {probe, addr, pix} = 10'('h010);
    en_led = 1'b1; vled = v; load = 1'b1;
    rd_req = 1'b1; rd_addr = 10'('h010);
    @(negedge clk);
    model_write('h010, 1'b1, v, ed, ea);
    chk("bypass_valid", 32'(rd_valid), 32'(1));
    chk("bypass_data", 32'(rd_data), 32'({1'b1, v}));
    load = 1'b0; rd_req = 1'b0;
    @(negedge clk);

    // reset in the middle of a sweep
    for (int i = 0; i < 10; i++) do_write(i, 1'b1, 3'd7, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_one('h010);
    do_write(10, 1'b1, 3'd2, 1);

`ifdef EPROBE_RX_HOLD_CHECK_EN
    {probe, addr, pix} = 10'('h123);
    en_led = 1'b1; vled = 3'd4; load = 1'b1;
    @(negedge clk);
    model_write('h123, 1'b1, 3'd4, ed, ea);
    vled = 3'd6;
    @(negedge clk);
    m_err = 1'b1;
    chk("hold_err_set", 32'(err), 32'(1));
    load = 1'b0;
    @(negedge clk);
    do_write('h124, 1'b0, 3'd1, 1);
    do_write('h125, 1'b1, 3'd2, 2);
    chk("hold_err_sticky", 32'(err), 32'(1));
    rst = 1'b0;
    #1;
    chk("hold_err_reset", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`else
    chk("err_tied", 32'(err), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
